// File: rtl/pipe_mult_pkg.sv
// Shared types and limits for the pipelined multiplier.
// Stage bundles are sized for the widest legal configuration.
package pipe_mult_pkg;

  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;
  localparam int TAG_MAX    = 32;
  localparam int PROD_MAX   = 2 * WIDTH_MAX;

  typedef struct packed {
    logic                valid;
    logic                is_signed;
    logic [TAG_MAX-1:0]  tag;
    logic [PROD_MAX-1:0] product;
  } stage_t;

endpackage

// File: rtl/pipe_mult_if.sv
// Request/result bundle of the pipelined multiplier.
// The requester drives master, the multiplier uses slave.
interface pipe_mult_if #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
);

  logic               start;
  logic               start_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               op_signed;
  logic [TAG_W-1:0]   tag_in;
  logic               done_mult;
  logic [2*WIDTH-1:0] result_mult;
  logic [TAG_W-1:0]   tag_out;
  logic               result_ready;

  modport master (
    output start, A, B, op_signed, tag_in,
    output result_ready,
    input  start_ready, done_mult,
    input  result_mult, tag_out
  );

  modport slave (
    input  start, A, B, op_signed, tag_in,
    input  result_ready,
    output start_ready, done_mult,
    output result_mult, tag_out
  );

endinterface

// File: rtl/mult_stage_reg.sv
// One enable-gated pipeline slot with synchronous clear.
// Used as a pure delay stage behind the multiply stage.
module mult_stage_reg
  import pipe_mult_pkg::*;
(
  input  logic   clk,
  input  logic   reset_n,
  input  logic   en,
  input  stage_t d,
  output stage_t q
);

  // hold unless the pipeline advances; clear on reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_mult_param.sv
// Pipelined signed/unsigned multiplier with tag sideband.
// Stage 1 multiplies, later stages only delay.
module pipe_mult_param
  import pipe_mult_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3,
  parameter int TAG_W  = 4
) (
  input logic      clk,
  input logic      reset_n,
  pipe_mult_if.slave bus
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $fatal(1, "pipe_mult_param: WIDTH out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $fatal(1, "pipe_mult_param: STAGES out of range");
  end
  if (TAG_W < 1 || TAG_W > TAG_MAX) begin : g_bad_tag
    $fatal(1, "pipe_mult_param: TAG_W out of range");
  end

  logic               advance;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  stage_t             head;
  stage_t             tail;
  stage_t             st [STAGES];

  // a full output slot blocks everything until it is taken
  assign advance         = !tail.valid || bus.result_ready;
  assign bus.start_ready = advance;

  // extend per mode; the low 2*WIDTH bits are exact either way
  always_comb begin
    a_ext = {{WIDTH{bus.op_signed & bus.A[WIDTH-1]}}, bus.A};
    b_ext = {{WIDTH{bus.op_signed & bus.B[WIDTH-1]}}, bus.B};
    prod  = a_ext * b_ext;
    head  = '0;
    head.valid     = bus.start;
    head.is_signed = bus.op_signed;
    head.tag[TAG_W-1:0]       = bus.tag_in;
    head.product[2*WIDTH-1:0] = prod;
  end

  // multiply stage register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      st[0] <= '0;
    end else if (advance) begin
      st[0] <= head;
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_dly
    mult_stage_reg u_reg (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (advance),
      .d       (st[k-1]),
      .q       (st[k])
    );
  end

  assign tail            = st[STAGES-1];
  assign bus.done_mult   = tail.valid;
  assign bus.result_mult = tail.product[2*WIDTH-1:0];
  assign bus.tag_out     = tail.tag[TAG_W-1:0];

  logic unused_tail;
  assign unused_tail = ^{tail.is_signed, tail.tag, tail.product};

endmodule
